tensor_core_readback: RTL and testbench
=======================================

TENSOR_CORE_READBACK -- requirements
Module: tensor_core_readback

Interface
REQ-001 The block SHALL have no parameters; element width is 8 bits, the register file holds 32 elements, and there are two 4x4 matrices.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clock_in  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n_in  input  1  asynchronous active-low reset.
REQ-005 start_in  input  1  request to begin a readback; sampled on the rising edge.
REQ-006 mode_in  input  2  readback scope, latched when a start is accepted: 00 = matrix 0, 01 = matrix 1, 10 or 11 = both matrices.
REQ-007 register_file_data_in  input  256  tensor core register file read data.
REQ-008 ready_in  input  1  downstream consumer ready.
REQ-009 data_out  output  8  current element.
REQ-010 valid_out  output  1  data_out holds a valid element.
REQ-011 index_out  output  5  register file address of the current element.
REQ-012 last_out  output  1  the current element is the final one of the readback.
REQ-013 busy_out  output  1  a readback is in progress.
REQ-014 done_out  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 Element address a SHALL occupy register_file_data_in[(31-a)*8 +: 8]; address a = n*16 + i*4 + j for matrix n, row i, column j.
REQ-016 The block SHALL implement three states:
- IDLE
- STREAM
- DONE
REQ-017 IDLE to STREAM SHALL occur on a rising edge with start_in=1. On that edge the block SHALL:
- snapshot all 256 bits of register_file_data_in into an internal buffer;
- latch mode_in;
- load the index counter with the start address: 0 for modes 00, 10 and 11; 16 for mode 01.
REQ-018 Latency SHALL be one cycle: valid_out=1 with the first element in the cycle after the start edge.
REQ-019 In STREAM:
- valid_out=1 and busy_out=1;
- data_out = snapshot element at index_out;
- output comes only from the snapshot; changes on register_file_data_in after the start edge SHALL NOT affect it.
REQ-020 A transfer SHALL occur on an edge with valid_out=1 and ready_in=1. After a non-final transfer, the index increments by 1.
REQ-021 While valid_out=1 and ready_in=0, data_out, index_out and last_out SHALL hold stable.
REQ-022 The end address SHALL be 15 for mode 00 and 31 for modes 01, 10 and 11. last_out=1 exactly when index_out equals the end address.
REQ-023 The transfer of the last element SHALL move the state to DONE. In DONE, done_out=1, valid_out=0 and busy_out=1 for exactly one cycle; the state then returns to IDLE.
REQ-024 start_in SHALL be ignored in STREAM and DONE. It is accepted again only in IDLE, so the earliest restart is the edge after DONE.
REQ-025 ready_in=1 with valid_out=0 SHALL have no effect.
REQ-026 The index counter SHALL NOT wrap past 31 under any mode.
REQ-027 Once valid_out=1, it SHALL NOT fall until the final transfer completes or reset asserts.

Reset
REQ-028 While reset_n_in=0, asynchronously:
- state = IDLE;
- valid_out = busy_out = done_out = last_out = 0;
- data_out = 0 and index_out = 0;
- snapshot buffer cleared to 0.
REQ-029 A reset asserted mid-readback SHALL abort it immediately with no further transfers; operation resumes only after a new start_in in IDLE following deassertion.

Verification
REQ-030 Mode 00 readback:
- stimulus: element a = a+1, ready_in held 1;
- response: valid_out rises one cycle after start; exactly 16 transfers of 0x01..0x10 at indices 0..15;
- last_out on index 15, then done_out for one cycle.
REQ-031 Mode 01 readback with ready_in toggling 1,0 every cycle:
- response: indices 16..31, 16 transfers, data stable during every ready_in=0 cycle;
- last_out on index 31.
REQ-032 Mode 10 readback with register_file_data_in changed to all 0xFF one cycle after start:
- response: 32 transfers of the original values 0x01..0x20;
- snapshot isolation holds.
REQ-033 start_in pulsed at the 5th transfer of a mode 00 readback:
- response: ignored; the readback completes normally;
- a start in the cycle after done_out begins a new readback.
REQ-034 reset_n_in driven low at the 7th element of a mode 10 readback:
- response: valid_out, busy_out and index_out clear to 0 with no clock edge;
- no done_out pulse; a subsequent start restarts from index 0.
REQ-035 ready_in held 0 for 10 cycles after start:
- response: valid_out=1, index_out=0 and data_out=0x01 held throughout;
- first transfer on the first edge with ready_in=1.

Source files
------------

// File: rtl/tensor_core_readback.sv
// Tensor core register file readback streamer.
//
// On an accepted start, snapshots the 256-bit register file (32 x 8-bit
// elements, two 4x4 matrices) and streams the selected matrix or matrices
// out one element per transfer under a valid/ready handshake.
//
// Ports:
//   clock_in              sole clock, rising edge
//   reset_n_in            asynchronous active-low reset
//   start_in              begin a readback (accepted only when idle)
//   mode_in               scope: 00 = matrix 0, 01 = matrix 1, 1x = both
//   register_file_data_in register file read data; element a at [(31-a)*8 +: 8]
//   ready_in              downstream consumer ready
//   data_out              current element
//   valid_out             data_out holds a valid element
//   index_out             register file address of the current element
//   last_out              current element is the final one of the readback
//   busy_out              readback in progress (stream and done cycles)
//   done_out              one-cycle pulse after the final transfer
module tensor_core_readback (
  input  logic         clock_in,
  input  logic         reset_n_in,
  input  logic         start_in,
  input  logic [1:0]   mode_in,
  input  logic [255:0] register_file_data_in,
  input  logic         ready_in,
  output logic [7:0]   data_out,
  output logic         valid_out,
  output logic [4:0]   index_out,
  output logic         last_out,
  output logic         busy_out,
  output logic         done_out
);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e       state_q;
  logic [255:0] snapshot_q;
  logic [1:0]   mode_q;
  logic [4:0]   index_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;
  logic         last_q;

  logic [4:0]   start_addr;
  logic [4:0]   end_addr;
  logic [4:0]   index_next;

  always_comb begin
    start_addr = (mode_in == 2'b01) ? 5'd16 : 5'd0;
    end_addr   = (mode_q == 2'b00) ? 5'd15 : 5'd31;
    // Only taken on a non-final transfer, so index_q < end_addr <= 31 and
    // the increment can never wrap.
    index_next = index_q + 5'd1;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StIdle;
      snapshot_q <= '0;
      mode_q     <= 2'b00;
      index_q    <= 5'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_in) begin
            state_q    <= StStream;
            snapshot_q <= register_file_data_in;
            mode_q     <= mode_in;
            index_q    <= start_addr;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            // Every scope spans at least 16 elements, so the first element
            // is never the last one.
            last_q     <= 1'b0;
          end
        end
        StStream: begin
          if (ready_in) begin
            if (last_q) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= index_next;
              last_q  <= (index_next == end_addr);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Element a lives at bit (31-a)*8; for a 5-bit address 31-a equals ~a.
  assign data_out  = snapshot_q[{~index_q, 3'b000} +: 8];
  assign valid_out = valid_q;
  assign index_out = index_q;
  assign last_out  = last_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_tensor_core_readback.sv
module tb_tensor_core_readback;

  logic         clock_in;
  logic         reset_n_in;
  logic         start_in;
  logic [1:0]   mode_in;
  logic [255:0] rf;
  logic         ready_in;
  logic [7:0]   data_out;
  logic         valid_out;
  logic [4:0]   index_out;
  logic         last_out;
  logic         busy_out;
  logic         done_out;

  logic [255:0] pattern;
  int           n_checks;
  int           n_errors;

  tensor_core_readback dut (
    .clock_in              (clock_in),
    .reset_n_in            (reset_n_in),
    .start_in              (start_in),
    .mode_in               (mode_in),
    .register_file_data_in (rf),
    .ready_in              (ready_in),
    .data_out              (data_out),
    .valid_out             (valid_out),
    .index_out             (index_out),
    .last_out              (last_out),
    .busy_out              (busy_out),
    .done_out              (done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Start a readback from idle and stream it to completion, returning in the
  // done cycle. ready_style: 0 = always 1, 1 = toggle 1,0,..., 2 = 0 for the
  // first 10 cycles then 1. start_pulse_at >= 0 drives start_in during that
  // transfer number.
  task automatic run_read(input logic [1:0] m, input int first_idx, input int last_idx,
                          input int ready_style, input bit corrupt, input int start_pulse_at,
                          input string tag);
    int exp_idx;
    int n;
    int total;
    logic rdy;
    check_eq({tag, "_idle_valid"}, {31'd0, valid_out}, 32'd0);
    check_eq({tag, "_idle_busy"}, {31'd0, busy_out}, 32'd0);
    mode_in  = m;
    start_in = 1'b1;
    ready_in = 1'b0;
    step();
    start_in = 1'b0;
    if (corrupt) rf = '1;
    exp_idx = first_idx;
    n       = 0;
    total   = last_idx - first_idx + 1;
    for (int c = 0; c < 200 && n < total; c++) begin
      case (ready_style)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = (c >= 10);
      endcase
      ready_in = rdy;
      start_in = (start_pulse_at >= 0 && n == start_pulse_at);
      check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
      check_eq({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
      check_eq({tag, "_index"}, {27'd0, index_out}, exp_idx);
      check_eq({tag, "_data"}, {24'd0, data_out}, exp_idx + 1);
      check_eq({tag, "_last"}, {31'd0, last_out}, {31'd0, exp_idx == last_idx});
      check_eq({tag, "_done_early"}, {31'd0, done_out}, 32'd0);
      step();
      if (rdy) begin
        exp_idx++;
        n++;
      end
    end
    start_in = 1'b0;
    ready_in = 1'b0;
    check_eq({tag, "_count"}, n, total);
    check_eq({tag, "_done"}, {31'd0, done_out}, 32'd1);
    check_eq({tag, "_done_valid"}, {31'd0, valid_out}, 32'd0);
    check_eq({tag, "_done_busy"}, {31'd0, busy_out}, 32'd1);
    check_eq({tag, "_done_last"}, {31'd0, last_out}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n_in = 1'b0;
    start_in   = 1'b0;
    mode_in    = 2'b00;
    ready_in   = 1'b0;
    for (int a = 0; a < 32; a++) pattern[(31 - a) * 8 +: 8] = 8'(a + 1);
    rf = pattern;

    // Reset state
    #2;
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
    check_eq("rst_done", {31'd0, done_out}, 32'd0);
    check_eq("rst_last", {31'd0, last_out}, 32'd0);
    check_eq("rst_index", {27'd0, index_out}, 32'd0);
    check_eq("rst_data", {24'd0, data_out}, 32'd0);
    step();
    reset_n_in = 1'b1;
    step();

    // Mode 00, ready held high
    run_read(2'b00, 0, 15, 0, 1'b0, -1, "m00");
    step();
    check_eq("m00_after_done", {31'd0, done_out}, 32'd0);
    check_eq("m00_after_busy", {31'd0, busy_out}, 32'd0);

    // Mode 01, ready toggling
    run_read(2'b01, 16, 31, 1, 1'b0, -1, "m01");
    step();

    // Mode 10, register file overwritten after start
    run_read(2'b10, 0, 31, 0, 1'b1, -1, "m10_iso");
    rf = pattern;
    step();

    // Start pulse mid-stream is ignored; start during done is ignored too;
    // start in the following idle cycle is accepted.
    run_read(2'b00, 0, 15, 0, 1'b0, 4, "m00_start");
    start_in = 1'b1;
    step();
    check_eq("restart_done_ignored", {31'd0, valid_out}, 32'd0);
    check_eq("restart_idle_busy", {31'd0, busy_out}, 32'd0);
    step();
    start_in = 1'b0;
    check_eq("restart_valid", {31'd0, valid_out}, 32'd1);
    check_eq("restart_index", {27'd0, index_out}, 32'd0);
    check_eq("restart_data", {24'd0, data_out}, 32'd1);
    ready_in = 1'b1;
    repeat (16) step();
    ready_in = 1'b0;
    check_eq("restart_done", {31'd0, done_out}, 32'd1);
    step();

    // Ready held low for 10 cycles after start
    run_read(2'b00, 0, 15, 2, 1'b0, -1, "hold");
    step();

    // Reset at the 7th element of a mode 10 readback
    mode_in  = 2'b10;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_eq("rst_mid_pre_index", {27'd0, index_out}, k);
      step();
    end
    check_eq("rst_mid_at7_index", {27'd0, index_out}, 32'd6);
    reset_n_in = 1'b0;
    #1;
    check_eq("rst_mid_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy_out}, 32'd0);
    check_eq("rst_mid_index", {27'd0, index_out}, 32'd0);
    check_eq("rst_mid_done", {31'd0, done_out}, 32'd0);
    check_eq("rst_mid_data", {24'd0, data_out}, 32'd0);
    step();
    step();
    reset_n_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rst_post_done", {31'd0, done_out}, 32'd0);
      check_eq("rst_post_valid", {31'd0, valid_out}, 32'd0);
    end
    ready_in = 1'b0;
    run_read(2'b10, 0, 31, 0, 1'b0, -1, "rst_restart");
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
